// File: rtl/mem_access_stage.sv
// Memory-access stage: passes ALU results through to writeback and runs a single
// outstanding load/store transaction with lane alignment, load extension and fault checks.
module mem_access_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] exe_result,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [4:0]            rd,
    input  logic                  reg_write,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_reg_write,
    output logic                  wb_fault
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                  state_q, state_d;

    logic                    dmem_req_q, dmem_req_d;
    logic                    dmem_we_q, dmem_we_d;
    logic [ADDR_WIDTH-1:0]   dmem_addr_q, dmem_addr_d;
    logic [DATA_WIDTH-1:0]   dmem_wdata_q, dmem_wdata_d;
    logic [3:0]              dmem_be_q, dmem_be_d;

    logic                    wb_valid_q, wb_valid_d;
    logic [4:0]              wb_rd_q, wb_rd_d;
    logic [DATA_WIDTH-1:0]   wb_data_q, wb_data_d;
    logic                    wb_reg_write_q, wb_reg_write_d;
    logic                    wb_fault_q, wb_fault_d;

    logic                    op_is_load_q, op_is_load_d;
    logic [1:0]              op_lane_q, op_lane_d;
    logic [1:0]              op_size_q, op_size_d;
    logic                    op_unsigned_q, op_unsigned_d;
    logic [4:0]              op_rd_q, op_rd_d;
    logic                    op_reg_write_q, op_reg_write_d;
    logic [DATA_WIDTH-1:0]   op_addr_q, op_addr_d;

    logic                    is_mem;
    logic                    fault;
    logic [1:0]              size;
    logic [1:0]              lane;
    logic [3:0]              st_be;
    logic [DATA_WIDTH-1:0]   st_wdata;
    logic [DATA_WIDTH-1:0]   ld_shifted;
    logic [DATA_WIDTH-1:0]   ld_value;

    assign in_ready     = (state_q == IDLE);
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign dmem_be      = dmem_be_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_fault     = wb_fault_q;

    // Decode of the incoming operation: fault check and store lane placement.
    always_comb begin
        size     = funct3[1:0];
        lane     = exe_result[1:0];
        is_mem   = mem_read | mem_write;
        fault    = (mem_read & mem_write)
                 | (size == 2'b11)
                 | ((size == 2'b01) & lane[0])
                 | ((size == 2'b10) & (lane != 2'b00));
        st_be    = 4'b1111;
        st_wdata = store_data;
        case (size)
            2'b00: begin
                st_be    = 4'b0001 << lane;
                st_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << lane;
                st_wdata = {2{store_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = store_data;
            end
        endcase
    end

    always_comb begin
        ld_shifted = dmem_rdata >> {op_lane_q, 3'b000};
        ld_value   = ld_shifted;
        case (op_size_q)
            2'b00: ld_value = op_unsigned_q
                            ? {{(DATA_WIDTH-8){1'b0}}, ld_shifted[7:0]}
                            : {{(DATA_WIDTH-8){ld_shifted[7]}}, ld_shifted[7:0]};
            2'b01: ld_value = op_unsigned_q
                            ? {{(DATA_WIDTH-16){1'b0}}, ld_shifted[15:0]}
                            : {{(DATA_WIDTH-16){ld_shifted[15]}}, ld_shifted[15:0]};
            default: ld_value = ld_shifted;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_wdata_d   = dmem_wdata_q;
        dmem_be_d      = dmem_be_q;
        wb_valid_d     = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_fault_d     = wb_fault_q;
        op_is_load_d   = op_is_load_q;
        op_lane_d      = op_lane_q;
        op_size_d      = op_size_q;
        op_unsigned_d  = op_unsigned_q;
        op_rd_d        = op_rd_q;
        op_reg_write_d = op_reg_write_q;
        op_addr_d      = op_addr_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        wb_valid_d     = 1'b1;
                        wb_rd_d        = rd;
                        wb_data_d      = exe_result;
                        wb_reg_write_d = reg_write & (rd != 5'd0);
                        wb_fault_d     = 1'b0;
                    end else if (fault) begin
                        wb_valid_d     = 1'b1;
                        wb_rd_d        = rd;
                        wb_data_d      = exe_result;
                        wb_reg_write_d = 1'b0;
                        wb_fault_d     = 1'b1;
                    end else begin
                        state_d        = ACCESS;
                        dmem_req_d     = 1'b1;
                        dmem_we_d      = mem_write;
                        dmem_addr_d    = {exe_result[ADDR_WIDTH-1:2], 2'b00};
                        dmem_be_d      = mem_write ? st_be : 4'b1111;
                        dmem_wdata_d   = mem_write ? st_wdata : '0;
                        op_is_load_d   = mem_read;
                        op_lane_d      = lane;
                        op_size_d      = size;
                        op_unsigned_d  = funct3[2];
                        op_rd_d        = rd;
                        op_reg_write_d = reg_write;
                        op_addr_d      = exe_result;
                    end
                end
            end
            ACCESS: begin
                // Request fields stay frozen until the memory acknowledges.
                if (dmem_ack) begin
                    state_d        = IDLE;
                    dmem_req_d     = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_rd_d        = op_rd_q;
                    wb_fault_d     = 1'b0;
                    wb_data_d      = op_is_load_q ? ld_value : op_addr_q;
                    wb_reg_write_d = op_is_load_q & op_reg_write_q & (op_rd_q != 5'd0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_wdata_q   <= '0;
            dmem_be_q      <= 4'b0000;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_data_q      <= '0;
            wb_reg_write_q <= 1'b0;
            wb_fault_q     <= 1'b0;
            op_is_load_q   <= 1'b0;
            op_lane_q      <= 2'b00;
            op_size_q      <= 2'b00;
            op_unsigned_q  <= 1'b0;
            op_rd_q        <= 5'd0;
            op_reg_write_q <= 1'b0;
            op_addr_q      <= '0;
        end else begin
            state_q        <= state_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_wdata_q   <= dmem_wdata_d;
            dmem_be_q      <= dmem_be_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_fault_q     <= wb_fault_d;
            op_is_load_q   <= op_is_load_d;
            op_lane_q      <= op_lane_d;
            op_size_q      <= op_size_d;
            op_unsigned_q  <= op_unsigned_d;
            op_rd_q        <= op_rd_d;
            op_reg_write_q <= op_reg_write_d;
            op_addr_q      <= op_addr_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed scenarios plus randomized operations
// checked against a behavioural model of alignment, extension and faults.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] exe_result = '0;
    logic [31:0] store_data = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rd = '0;
    logic        reg_write = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_reg_write;
    logic        wb_fault;

    int total = 0;
    int bad = 0;

    mem_access_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .exe_result(exe_result), .store_data(store_data),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .rd(rd), .reg_write(reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_reg_write(wb_reg_write), .wb_fault(wb_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input logic [4:0] r, input logic rw);
        in_valid   = 1'b1;
        mem_read   = rd_en;
        mem_write  = wr_en;
        funct3     = f3;
        exe_result = a;
        store_data = sd;
        rd         = r;
        reg_write  = rw;
    endtask

    // Reference model, expressed as byte arithmetic rather than bit slicing.
    function automatic logic model_fault(input logic rd_en, input logic wr_en,
                                         input logic [2:0] f3, input logic [31:0] a);
        int bytes;
        if (rd_en && wr_en) return 1'b1;
        if (f3[1:0] == 2'd3) return 1'b1;
        bytes = 1 << f3[1:0];
        return (a % bytes) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input int lane,
                                               input int size, input logic uns);
        longint v;
        v = longint'(rdata) / (longint'(1) << (8 * lane));
        if (size == 0) begin
            v = v % 256;
            if (!uns && v > 127) v = v - 256;
        end else if (size == 1) begin
            v = v % 65536;
            if (!uns && v > 32767) v = v - 65536;
        end else begin
            v = longint'(rdata);
        end
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_be(input int size, input int lane);
        if (size == 0) return 4'(1 << lane);
        if (size == 1) return 4'(3 << lane);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input int size, input logic [31:0] sd);
        if (size == 0) return 32'(longint'(sd % 256) * 32'h01010101);
        if (size == 1) return 32'(longint'(sd % 65536) * 32'h00010001);
        return sd;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
             wb_valid, wb_rd, wb_data, wb_reg_write, wb_fault} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got req=%b we=%b addr=%h wdata=%h be=%b wb_valid=%b wb_data=%h expected all zero",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_valid, wb_data);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready);
        end
    endtask

    task automatic test_passthrough();
        drive_op(0, 0, 3'b000, 32'h64, 32'h0, 5'd5, 1);
        tick();
        in_valid = 1'b0;
        total++;
        if ({wb_valid, wb_rd, wb_data, wb_reg_write, wb_fault, dmem_req} !==
            {1'b1, 5'd5, 32'h64, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL passthrough got valid=%b rd=%0d data=%h rw=%b fault=%b req=%b expected 1 5 00000064 1 0 0",
                     wb_valid, wb_rd, wb_data, wb_reg_write, wb_fault, dmem_req);
        end
        tick();
        total++;
        if (wb_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL passthrough_pulse got wb_valid=%b expected 0", wb_valid);
        end
    endtask

    task automatic test_byte_load();
        for (int uns = 0; uns < 2; uns++) begin
            drive_op(1, 0, {uns[0], 2'b00}, 32'h1003, 32'h0, 5'd7, 1);
            tick();
            in_valid = 1'b0;
            total++;
            if ({dmem_req, dmem_we, dmem_be, dmem_addr, in_ready} !==
                {1'b1, 1'b0, 4'hF, 32'h1000, 1'b0}) begin
                bad++;
                $display("[TB] FAIL byte_load_req got req=%b we=%b be=%b addr=%h ready=%b expected 1 0 1111 00001000 0",
                         dmem_req, dmem_we, dmem_be, dmem_addr, in_ready);
            end
            for (int w = 0; w < 2; w++) begin
                tick();
                total++;
                if ({dmem_req, wb_valid, dmem_addr} !== {1'b1, 1'b0, 32'h1000}) begin
                    bad++;
                    $display("[TB] FAIL byte_load_hold got req=%b wb_valid=%b addr=%h expected 1 0 00001000",
                             dmem_req, wb_valid, dmem_addr);
                end
            end
            dmem_ack   = 1'b1;
            dmem_rdata = 32'h80FF1234;
            tick();
            dmem_ack = 1'b0;
            total++;
            if ({wb_valid, wb_rd, wb_data, wb_reg_write, wb_fault, dmem_req} !==
                {1'b1, 5'd7, (uns == 1) ? 32'h00000080 : 32'hFFFFFF80, 1'b1, 1'b0, 1'b0}) begin
                bad++;
                $display("[TB] FAIL byte_load_wb uns=%0d got valid=%b data=%h rw=%b fault=%b req=%b",
                         uns, wb_valid, wb_data, wb_reg_write, wb_fault, dmem_req);
            end
            tick();
        end
    endtask

    task automatic test_half_store();
        drive_op(0, 1, 3'b001, 32'h2002, 32'h1234ABCD, 5'd9, 1);
        tick();
        in_valid = 1'b0;
        total++;
        if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !==
            {1'b1, 1'b1, 4'b1100, 32'h2000, 32'hABCDABCD}) begin
            bad++;
            $display("[TB] FAIL half_store_req got req=%b we=%b be=%b addr=%h wdata=%h expected 1 1 1100 00002000 abcdabcd",
                     dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata);
        end
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        total++;
        if ({wb_valid, wb_reg_write, wb_fault, wb_data, dmem_req} !==
            {1'b1, 1'b0, 1'b0, 32'h2002, 1'b0}) begin
            bad++;
            $display("[TB] FAIL half_store_wb got valid=%b rw=%b fault=%b data=%h req=%b expected 1 0 0 00002002 0",
                     wb_valid, wb_reg_write, wb_fault, wb_data, dmem_req);
        end
        tick();
    endtask

    task automatic test_fault();
        drive_op(1, 0, 3'b010, 32'h1002, 32'h0, 5'd3, 1);
        tick();
        in_valid = 1'b0;
        total++;
        if ({dmem_req, wb_valid, wb_rd, wb_data, wb_reg_write, wb_fault, in_ready} !==
            {1'b0, 1'b1, 5'd3, 32'h1002, 1'b0, 1'b1, 1'b1}) begin
            bad++;
            $display("[TB] FAIL misaligned_word got req=%b valid=%b data=%h rw=%b fault=%b ready=%b expected 0 1 00001002 0 1 1",
                     dmem_req, wb_valid, wb_data, wb_reg_write, wb_fault, in_ready);
        end
        tick();
        drive_op(1, 0, 3'b100, 32'h40, 32'h0, 5'd0, 1);
        tick();
        in_valid   = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h000000AB;
        tick();
        dmem_ack = 1'b0;
        total++;
        if ({wb_valid, wb_rd, wb_data, wb_reg_write, wb_fault} !==
            {1'b1, 5'd0, 32'hAB, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL load_rd0 got valid=%b rd=%0d data=%h rw=%b fault=%b expected 1 0 000000ab 0 0",
                     wb_valid, wb_rd, wb_data, wb_reg_write, wb_fault);
        end
        tick();
    endtask

    task automatic test_reset_in_access();
        drive_op(1, 0, 3'b010, 32'h3000, 32'h0, 5'd4, 1);
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({dmem_req, in_ready, wb_valid} !== {1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL reset_in_access got req=%b ready=%b wb_valid=%b expected 0 1 0",
                     dmem_req, in_ready, wb_valid);
        end
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        total++;
        if ({wb_valid, dmem_req} !== {1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL stale_ack got wb_valid=%b req=%b expected 0 0", wb_valid, dmem_req);
        end
    endtask

    task automatic test_ack_in_idle();
        dmem_ack = 1'b1;
        tick();
        tick();
        dmem_ack = 1'b0;
        total++;
        if ({wb_valid, dmem_req, in_ready} !== {1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL ack_in_idle got wb_valid=%b req=%b ready=%b expected 0 0 1",
                     wb_valid, dmem_req, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        drive_op(1, 0, 3'b010, 32'h4000, 32'h0, 5'd6, 1);
        tick();
        drive_op(0, 0, 3'b000, 32'hCAFE, 32'h0, 5'd8, 1);
        total++;
        if ({in_ready, dmem_req} !== {1'b0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL b2b_access1 got ready=%b req=%b expected 0 1", in_ready, dmem_req);
        end
        tick();
        total++;
        if ({in_ready, dmem_req, wb_valid} !== {1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL b2b_access2 got ready=%b req=%b wb_valid=%b expected 0 1 0",
                     in_ready, dmem_req, wb_valid);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h11223344;
        tick();
        dmem_ack = 1'b0;
        total++;
        if ({wb_valid, wb_rd, wb_data, in_ready} !== {1'b1, 5'd6, 32'h11223344, 1'b1}) begin
            bad++;
            $display("[TB] FAIL b2b_load_wb got valid=%b rd=%0d data=%h ready=%b expected 1 6 11223344 1",
                     wb_valid, wb_rd, wb_data, in_ready);
        end
        tick();
        in_valid = 1'b0;
        total++;
        if ({wb_valid, wb_rd, wb_data, wb_reg_write} !== {1'b1, 5'd8, 32'hCAFE, 1'b1}) begin
            bad++;
            $display("[TB] FAIL b2b_second_wb got valid=%b rd=%0d data=%h rw=%b expected 1 8 0000cafe 1",
                     wb_valid, wb_rd, wb_data, wb_reg_write);
        end
        tick();
        total++;
        if (wb_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_idle got wb_valid=%b expected 0", wb_valid);
        end
    endtask

    task automatic test_random_mix();
        for (int n = 0; n < 60; n++) begin
            logic        r_en, w_en, rw, flt;
            logic [2:0]  f3;
            logic [31:0] a, sd, rdata, exp_data;
            logic [4:0]  r;
            int          kind, waits, size, lane;
            kind = $urandom_range(0, 3);
            r_en = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
            w_en = (kind == 2) || (kind == 3);
            f3   = 3'($urandom_range(0, 7));
            a    = $urandom;
            if ($urandom_range(0, 2) != 0) a = a - (a % (1 << (f3 % 3)));
            sd   = $urandom;
            r    = 5'($urandom_range(0, 31));
            rw   = 1'($urandom_range(0, 1));
            size = f3 % 4;
            lane = a % 4;
            drive_op(r_en, w_en, f3, a, sd, r, rw);
            tick();
            in_valid = 1'b0;
            flt = model_fault(r_en, w_en, f3, a);
            if (!r_en && !w_en) begin
                total++;
                if ({wb_valid, wb_rd, wb_data, wb_reg_write, wb_fault, dmem_req} !==
                    {1'b1, r, a, rw && (r != 0), 1'b0, 1'b0}) begin
                    bad++;
                    $display("[TB] FAIL rand_pass n=%0d got valid=%b rd=%0d data=%h rw=%b fault=%b req=%b expected data=%h",
                             n, wb_valid, wb_rd, wb_data, wb_reg_write, wb_fault, dmem_req, a);
                end
            end else if (flt) begin
                total++;
                if ({wb_valid, wb_rd, wb_data, wb_reg_write, wb_fault, dmem_req} !==
                    {1'b1, r, a, 1'b0, 1'b1, 1'b0}) begin
                    bad++;
                    $display("[TB] FAIL rand_fault n=%0d f3=%b a=%h got valid=%b data=%h rw=%b fault=%b req=%b",
                             n, f3, a, wb_valid, wb_data, wb_reg_write, wb_fault, dmem_req);
                end
            end else begin
                total++;
                if ({dmem_req, dmem_we, dmem_addr, dmem_be} !==
                    {1'b1, w_en, a - (a % 4), w_en ? model_be(size, lane) : 4'hF} ||
                    (w_en && dmem_wdata !== model_wdata(size, sd))) begin
                    bad++;
                    $display("[TB] FAIL rand_req n=%0d got req=%b we=%b addr=%h be=%b wdata=%h expected we=%b be=%b wdata=%h",
                             n, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                             w_en, model_be(size, lane), model_wdata(size, sd));
                end
                waits = $urandom_range(0, 3);
                for (int w = 0; w < waits; w++) begin
                    dmem_rdata = $urandom;
                    tick();
                    total++;
                    if ({dmem_req, wb_valid, in_ready} !== {1'b1, 1'b0, 1'b0}) begin
                        bad++;
                        $display("[TB] FAIL rand_wait n=%0d got req=%b wb_valid=%b ready=%b expected 1 0 0",
                                 n, dmem_req, wb_valid, in_ready);
                    end
                end
                rdata      = $urandom;
                dmem_rdata = rdata;
                dmem_ack   = 1'b1;
                tick();
                dmem_ack = 1'b0;
                exp_data = r_en ? model_load(rdata, lane, size, f3[2]) : a;
                total++;
                if ({wb_valid, wb_rd, wb_data, wb_reg_write, wb_fault, dmem_req} !==
                    {1'b1, r, exp_data, r_en && rw && (r != 0), 1'b0, 1'b0}) begin
                    bad++;
                    $display("[TB] FAIL rand_wb n=%0d f3=%b a=%h rdata=%h got valid=%b data=%h rw=%b fault=%b expected data=%h",
                             n, f3, a, rdata, wb_valid, wb_data, wb_reg_write, wb_fault, exp_data);
                end
            end
            tick();
            total++;
            if (wb_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL rand_pulse n=%0d got wb_valid=%b expected 0", n, wb_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_byte_load();
        test_half_store();
        test_fault();
        test_reset_in_access();
        test_ack_in_idle();
        test_back_to_back();
        test_random_mix();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
